// File: rtl/banked_mem_responder_if.sv
// Banked DFP bus: line-address requests, 4-beat 64-bit write
// bursts, and in-order 4-beat read bursts back to the initiator.
interface banked_mem_responder_if;
  logic [31:0] dfp_addr;
  logic        dfp_read;
  logic        dfp_write;
  logic [63:0] dfp_wdata;
  logic        dfp_ready;
  logic [31:0] dfp_raddr;
  logic [63:0] dfp_rdata;
  logic        dfp_rvalid;

  modport master (
    output dfp_addr,
    output dfp_read,
    output dfp_write,
    output dfp_wdata,
    input  dfp_ready,
    input  dfp_raddr,
    input  dfp_rdata,
    input  dfp_rvalid
  );

  modport slave (
    input  dfp_addr,
    input  dfp_read,
    input  dfp_write,
    input  dfp_wdata,
    output dfp_ready,
    output dfp_raddr,
    output dfp_rdata,
    output dfp_rvalid
  );
endinterface

// File: rtl/banked_mem_responder.sv
// Line-granular memory responder: 4-beat write bursts, snapshot
// read queue with fixed latency, in-order 4-beat read bursts.
module banked_mem_responder #(
  parameter int INDEX_BITS   = 4,
  parameter int READ_LATENCY = 4,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  banked_mem_responder_if.slave dfp,
  output logic                  err
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int PW    = $clog2(QUEUE_DEPTH);
  localparam int CW    = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_B1,
    W_B2,
    W_B3
  } wstate_t;

  wstate_t ws, ws_nx;

  logic [255:0]          mem [LINES];
  logic [63:0]           wbuf [3];
  logic [INDEX_BITS-1:0] widx;

  logic [26:0]  q_addr [QUEUE_DEPTH];
  logic [255:0] q_line [QUEUE_DEPTH];
  logic [CW-1:0] q_cnt [QUEUE_DEPTH];
  logic [PW:0]  wp, rp, wp_nx, rp_nx;
  logic [PW-1:0] wslot, rslot;

  logic         ready_q;
  logic         rvalid_q;
  logic [1:0]   rbeat, rbeat_nx;
  logic [26:0]  raddr_q;
  logic [63:0]  rdata_q;
  logic [255:0] rbuf;

  logic rd, wr, idle, commit;
  logic rd_acc, wr_start;
  logic bypass, head_due, burst_done, pop;
  logic full_nx, bad;
  logic [INDEX_BITS-1:0] ridx;
  logic [255:0] cline, snap;
  logic unused_lo;

  assign rd        = dfp.dfp_read;
  assign wr        = dfp.dfp_write;
  assign ridx      = dfp.dfp_addr[5 +: INDEX_BITS];
  assign unused_lo = ^dfp.dfp_addr[4:0];

  assign idle     = (ws == W_IDLE);
  assign commit   = (ws == W_B3);
  assign rd_acc   = rd & ready_q & ~wr & idle;
  assign wr_start = wr & ready_q & ~rd & idle;

  assign cline = {dfp.dfp_wdata, wbuf[2], wbuf[1], wbuf[0]};
  // A read snapshot racing a commit to the same line sees the new data
  assign bypass = commit && (ridx == widx);
  assign snap   = bypass ? cline : mem[ridx];

  assign wslot      = wp[PW-1:0];
  assign rslot      = rp[PW-1:0];
  assign head_due   = (wp != rp) && (q_cnt[rslot] == '0);
  assign burst_done = !rvalid_q || (rbeat == 2'd3);
  assign pop        = burst_done && head_due;
  assign rbeat_nx   = rbeat + 2'd1;

  assign wp_nx   = wp + {{PW{1'b0}}, rd_acc};
  assign rp_nx   = rp + {{PW{1'b0}}, pop};
  assign full_nx = (wp_nx[PW] != rp_nx[PW]) &&
                   (wp_nx[PW-1:0] == rp_nx[PW-1:0]);

  assign bad = (rd & wr)
             | (rd & ~idle)
             | ((rd | wr) & ~ready_q)
             | (~idle & ~wr);

  always_comb begin
    ws_nx = ws;
    unique case (ws)
      W_IDLE: if (wr_start) ws_nx = W_B1;
      W_B1:   ws_nx = W_B2;
      W_B2:   ws_nx = W_B3;
      W_B3:   ws_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws       <= W_IDLE;
      wp       <= '0;
      rp       <= '0;
      ready_q  <= 1'b0;
      err      <= 1'b0;
      rvalid_q <= 1'b0;
      rbeat    <= 2'd0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_cnt[i] <= '0;
      end
    end else begin
      ws      <= ws_nx;
      wp      <= wp_nx;
      rp      <= rp_nx;
      ready_q <= (ws_nx != W_IDLE) || !full_nx;
      err     <= err | bad;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - 1'b1;
      end
      if (rd_acc) q_cnt[wslot] <= CNT_INIT;
      if (rvalid_q && rbeat != 2'd3) begin
        rbeat   <= rbeat_nx;
        rdata_q <= rbuf[{rbeat_nx, 6'd0} +: 64];
      end else if (pop) begin
        rvalid_q <= 1'b1;
        rbeat    <= 2'd0;
        raddr_q  <= q_addr[rslot];
        rdata_q  <= q_line[rslot][63:0];
      end else begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Storage and data buffers are not reset; control state guards them
  always_ff @(posedge clk) begin
    if (wr_start) begin
      wbuf[0] <= dfp.dfp_wdata;
      widx    <= ridx;
    end
    if (ws == W_B1) wbuf[1] <= dfp.dfp_wdata;
    if (ws == W_B2) wbuf[2] <= dfp.dfp_wdata;
    if (commit) mem[widx] <= cline;
    if (rd_acc) begin
      q_addr[wslot] <= dfp.dfp_addr[31:5];
      q_line[wslot] <= snap;
    end
    if (pop) rbuf <= q_line[rslot];
  end

  assign dfp.dfp_ready  = ready_q;
  assign dfp.dfp_rvalid = rvalid_q;
  assign dfp.dfp_raddr  = {raddr_q, 5'b0};
  assign dfp.dfp_rdata  = rdata_q;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Bench for banked_mem_responder: directed protocol cases plus
// random traffic against a line-array and beat-schedule model.
`define CHK(tag, obs, exp) begin \
  tests++; \
  assert ((obs) === (exp)) else begin \
    fails++; \
    $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
  end \
end

module tb_banked_mem_responder;
  localparam int IB  = 4;
  localparam int LAT = 4;
  localparam int QD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  banked_mem_responder_if bus();

  banked_mem_responder #(
    .INDEX_BITS(IB),
    .READ_LATENCY(LAT),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dfp(bus),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [31:0] a;
    logic [63:0] d;
  } beat_t;

  beat_t        exp_q[$];
  int           pend_f[$];
  logic [255:0] mm [16];
  int           last_end;
  int           cyc;
  bit           live;
  bit           chk_en;
  int           tests;
  int           fails;

  function automatic int lidx(input logic [31:0] a);
    return int'(a[8:5]);
  endfunction

  function automatic logic [255:0] rline();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Requests outstanding = accepted reads whose first beat is still ahead
  function automatic bit mdl_ready();
    while (pend_f.size() > 0 && pend_f[0] <= cyc) void'(pend_f.pop_front());
    return live && (pend_f.size() < QD);
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
        `CHK("rvalid", bus.dfp_rvalid, 1'b1)
        `CHK("raddr", bus.dfp_raddr, exp_q[0].a)
        `CHK("rdata", bus.dfp_rdata, exp_q[0].d)
        void'(exp_q.pop_front());
      end else begin
        `CHK("rvalid_idle", bus.dfp_rvalid, 1'b0)
      end
    end
  end

  task automatic wait_ready(input string tag, output bit ok);
    int n = 0;
    while (!mdl_ready() && n < 200) begin
      step();
      n++;
    end
    ok = mdl_ready();
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL %s: ready wait expired", tag);
    end else `CHK(tag, bus.dfp_ready, 1'b1)
  endtask

  task automatic do_read(input logic [31:0] a);
    bit    ok;
    int    first;
    beat_t bt;
    wait_ready("rd_ready", ok);
    if (!ok) return;
    bus.dfp_addr = a;
    bus.dfp_read = 1'b1;
    step();
    bus.dfp_read = 1'b0;
    first = (cyc + LAT > last_end + 1) ? cyc + LAT : last_end + 1;
    for (int b = 0; b < 4; b++) begin
      bt.t = first + b;
      bt.a = {a[31:5], 5'b0};
      bt.d = mm[lidx(a)][64*b +: 64];
      exp_q.push_back(bt);
    end
    last_end = first + 3;
    pend_f.push_back(first);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                          input bit drop2);
    bit ok;
    wait_ready("wr_ready", ok);
    if (!ok) return;
    for (int b = 0; b < 4; b++) begin
      bus.dfp_addr  = a;
      bus.dfp_write = !(drop2 && b == 2);
      bus.dfp_wdata = line[64*b +: 64];
      step();
    end
    bus.dfp_write = 1'b0;
    mm[lidx(a)] = line;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $error("FAIL drain: %0d beats still expected", exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic apply_reset();
    bus.dfp_read  = 1'b0;
    bus.dfp_write = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    pend_f.delete();
    last_end = -100;
    live = 1'b0;
    #1;
    `CHK("rst_rvalid", bus.dfp_rvalid, 1'b0)
    `CHK("rst_ready", bus.dfp_ready, 1'b0)
    `CHK("rst_err", err, 1'b0)
    `CHK("rst_raddr", bus.dfp_raddr, 32'h0)
    `CHK("rst_rdata", bus.dfp_rdata, 64'h0)
    chk_en = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    live = 1'b1;
  endtask

  initial begin
    logic [255:0] l1;
    logic [255:0] ones;
    tests = 0;
    fails = 0;
    cyc = 0;
    chk_en = 1'b0;
    live = 1'b0;
    last_end = -100;
    bus.dfp_addr  = '0;
    bus.dfp_read  = 1'b0;
    bus.dfp_write = 1'b0;
    bus.dfp_wdata = '0;
    #2;
    apply_reset();

    for (int i = 0; i < 16; i++) do_write(32'(i) << 5, rline(), 1'b0);

    // 1: basic write then read, exact latency
    l1 = {64'h1eceb0061eceb007, 64'h1eceb0041eceb005,
          64'h1eceb0021eceb003, 64'h1eceb0001eceb001};
    do_write(32'h1eceb000, l1, 1'b0);
    do_read(32'h1eceb000);
    drain();
    `CHK("t1_err", err, 1'b0)

    // 2: fill the queue, ready tracks occupancy
    do_read(32'h00);
    do_read(32'h20);
    do_read(32'h40);
    do_read(32'h60);
    `CHK("t2_full_ready", bus.dfp_ready, 1'b0)
    for (int i = 0; i < 6; i++) begin
      step();
      `CHK("t2_ready_track", bus.dfp_ready, mdl_ready())
    end
    drain();

    // 3: read snapshot precedes a later write to the same line
    ones = '1;
    do_read(32'h40);
    do_write(32'h40, ones, 1'b0);
    do_read(32'h40);
    drain();
    `CHK("t3_err", err, 1'b0)

    // 4: read and write together are rejected, err sticks
    bus.dfp_addr  = 32'h80;
    bus.dfp_wdata = 64'hdead;
    bus.dfp_read  = 1'b1;
    bus.dfp_write = 1'b1;
    step();
    bus.dfp_read  = 1'b0;
    bus.dfp_write = 1'b0;
    `CHK("t4_err", err, 1'b1)
    repeat (6) step();
    `CHK("t4_err_sticky", err, 1'b1)
    `CHK("t4_ready", bus.dfp_ready, 1'b1)
    do_read(32'h80);
    drain();
    `CHK("t4_err_still", err, 1'b1)

    // 5: reset mid write burst with reads pending
    do_read(32'h120);
    step();
    do_read(32'h140);
    do_read(32'h160);
    l1 = rline();
    for (int b = 0; b < 2; b++) begin
      bus.dfp_addr  = 32'hA0;
      bus.dfp_write = 1'b1;
      bus.dfp_wdata = l1[64*b +: 64];
      step();
    end
    `CHK("t5_pre_rvalid", bus.dfp_rvalid, 1'b1)
    bus.dfp_wdata = l1[128 +: 64];
    apply_reset();
    repeat (20) step();
    do_read(32'hA0);
    drain();

    // 6: write strobe dropped mid burst still commits
    `CHK("t6_err_clear", err, 1'b0)
    do_write(32'hE0, rline(), 1'b1);
    `CHK("t6_err", err, 1'b1)
    do_read(32'hE0);
    drain();

    // random legal traffic
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) do_read({$urandom} & 32'hffff_fffe);
      else if (r < 8) do_write($urandom, rline(), 1'b0);
      else repeat ($urandom_range(1, 6)) step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/banked_mem_responder.md
Name: banked_mem_responder

Overview:
Synthesizable responder for the banked DFP memory protocol that cacheline_adapter drives as initiator. It accepts 4-beat 64-bit write bursts and single-cycle read requests, stores whole 256-bit lines, and returns read data as in-order 4-beat bursts after a fixed latency. It stands in for banked memory in block-level and FPGA benches of the cache/adapter path.

Parameters:
INDEX_BITS, 4, line-index width; storage = 2^INDEX_BITS lines of 256 bits, indexed by dfp_addr[5+INDEX_BITS-1:5]
READ_LATENCY, 4, minimum cycles from read acceptance edge to first rvalid beat; legal range >= 1
QUEUE_DEPTH, 4, outstanding read requests held; power of two, >= 2

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
dfp_addr  in  32  line address; bits [4:0] ignored
dfp_read  in  1  read request, valid for one cycle when dfp_ready is high
dfp_write  in  1  write burst; held high for 4 consecutive cycles
dfp_wdata  in  64  write beat data, beat 0 = line bits [63:0]
dfp_ready  out  1  responder can accept a request this cycle
dfp_raddr  out  32  line address of the current read beat (addr with [4:0] = 0)
dfp_rdata  out  64  read beat data
dfp_rvalid  out  1  read beat valid
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst low, async): dfp_ready=0, dfp_rvalid=0, dfp_raddr=0, dfp_rdata=0, err=0, queue empty, write FSM in W_IDLE, beat counter 0. The storage array is not reset. Asserting reset mid-burst drops any partial write (no commit) and all queued or in-flight reads.
- dfp_ready = 1 in W_IDLE when queue is not full. dfp_ready = 1 throughout W_B1..W_B3. 0 otherwise.
- Write FSM, states W_IDLE, W_B1, W_B2, W_B3:
  - W_IDLE -> W_B1 on write && ready && !read. Capture beat 0 and the address.
  - W_Bn -> next state: capture beat n. Address is not resampled.
  - W_B3 -> W_IDLE: commit the 256-bit line to the array at that edge.
  - dfp_write low in W_B1..W_B3 sets err. Beats are still captured and the line still commits (count-based).
- Read accept: read && ready && !write in W_IDLE pushes an entry {line addr, 256-bit snapshot of array line, countdown=READ_LATENCY-1}. Data is snapshotted at acceptance, so a later write to the same line does not affect a queued read.
- Read-accept address hazard: a read accepted on the same edge a W_B3 commit targets the same line returns the NEW data (bypass).
- Illegal request forms, all of which set err and are ignored (not accepted):
  - read && write in the same cycle.
  - read during W_B1..W_B3.
  - a request while dfp_ready is low.
- Countdown: every queued entry decrements by 1 per cycle, saturating at 0.
- Beat engine: when idle and the head countdown is 0, it pops the head and drives 4 consecutive beats.
  - dfp_rvalid=1, dfp_raddr=entry addr, dfp_rdata=line[64*b+63:64*b] for b=0..3.
  - No gaps between beats; bursts are in request order.
  - A new burst may start the cycle after beat 3, giving back-to-back bursts.
- Latency: read accepted at edge k -> first beat registered at edge k+READ_LATENCY. Later requests also wait behind earlier bursts.
- Simultaneous push and pop on a full queue: pop frees a slot next cycle. ready reflects registered occupancy, so there is no same-cycle fall-through.
- Occupancy counter wraps in modulo QUEUE_DEPTH pointers. Use an extra pointer bit for the full/empty distinction.
- dfp_rvalid=0 between bursts. dfp_rdata/dfp_raddr hold their last values when not valid.

Test Plan:
1. Reset release, then write 0x1eceb000 with beats 0x1eceb0001eceb001, 0x1eceb0021eceb003, 0x1eceb0041eceb005, 0x1eceb0061eceb007; read 0x1eceb000 -> 4 rvalid beats in that order, raddr=0x1eceb000, first beat exactly READ_LATENCY edges after acceptance, err=0.
2. Fill queue: 4 back-to-back reads of lines 0x00,0x20,0x40,0x60 (pre-written with distinct patterns) -> ready drops after the 4th; 16 contiguous rvalid beats in request order; ready returns after first pop.
3. Read 0x40 accepted, then write 0x40 with all-0xFF beats before response -> read returns pre-write data; a following read returns 0xFF…FF.
4. Read and write asserted in the same cycle at 0x80 -> neither accepted, err=1 and stays 1; a subsequent legal read still completes.
5. Assert rst low during beat 2 of a write to 0xA0 and with 2 reads queued -> rvalid=0 and ready=0 immediately; after release no stale beats appear; old 0xA0 content is unchanged.
6. dfp_write dropped in W_B2 -> err=1; the line still commits with the captured beats.
